// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command sequencer: FSM state encoding,
// command opcodes, default frame/reply marker bytes and frame length.
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [3:0] {
    S_HDR    = 4'd0,
    S_CMD    = 4'd1,
    S_ADDR   = 4'd2,
    S_DATA   = 4'd3,
    S_CHK    = 4'd4,
    S_EXEC   = 4'd5,
    S_RDWAIT = 4'd6,
    S_TXHDR  = 4'd7,
    S_TXDAT  = 4'd8
  } state_t;

  localparam logic [7:0] CMD_WR       = 8'h01;
  localparam logic [7:0] CMD_RD       = 8'h02;
  localparam logic [7:0] HDR_BYTE_DEF = 8'hAA;
  localparam logic [7:0] RSP_BYTE_DEF = 8'h55;

  // HDR, CMD, ADDR, DATA, CHK
  localparam int FRAME_LEN = 5;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl_if
// Bundles the byte stream from the UART receiver, the register-bank strobes,
// the reply stream to the UART transmitter and the status outputs.
//   slave  : the command sequencer (consumes rx bytes, drives reg/tx/status)
//   master : the surrounding environment (PHYs + register bank)
// ---------------------------------------------------------------------------
interface uart_cmd_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [7:0]        reg_wr_data;
  logic [7:0]        reg_rd_data;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;
  logic              busy;
  logic              frame_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  rx_valid, rx_data, reg_rd_data, tx_ready,
    output reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
           tx_valid, tx_data, busy, frame_err, err_cnt
  );

  modport master (
    output rx_valid, rx_data, reg_rd_data, tx_ready,
    input  reg_wr_en, reg_rd_en, reg_addr, reg_wr_data,
           tx_valid, tx_data, busy, frame_err, err_cnt
  );
endinterface

// File: rtl/uart_cmd_timeout.sv
// ---------------------------------------------------------------------------
// uart_cmd_timeout
// Inter-byte idle counter. Clear has priority over enable; the counter stops
// at the terminal value so o_tc stays high until cleared.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_clr      : load zero
//   i_en       : count one cycle
//   o_tc       : counter == TIMEOUT_CYC-1
// ---------------------------------------------------------------------------
module uart_cmd_timeout #(
  parameter int TIMEOUT_CYC = 208320
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             r_cnt <= '0;
    else if (i_clr)         r_cnt <= '0;
    else if (i_en && !o_tc) r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = (r_cnt == TC_VAL);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// uart_cmd_ctrl
// Assembles 5-byte command frames (HDR CMD ADDR DATA CHK, CHK = CMD^ADDR^DATA)
// from the UART receiver, executes register writes, and for reads sends a
// two-byte reply (RSP_BYTE, data) to the UART transmitter.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : uart_cmd_ctrl_if.slave
//                rx_valid/rx_data        byte strobe from receiver
//                reg_wr_en/reg_rd_en     one-cycle register strobes
//                reg_addr/reg_wr_data    last accepted frame's address/data
//                reg_rd_data             valid the cycle after reg_rd_en
//                tx_valid/tx_data/tx_ready reply handshake
//                busy                    any state but S_HDR
//                frame_err/err_cnt       discard pulse, saturating count
// ---------------------------------------------------------------------------
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int         ADDR_W      = 8,
  parameter int         TIMEOUT_CYC = 208320,
  parameter logic [7:0] HDR_BYTE    = HDR_BYTE_DEF,
  parameter logic [7:0] RSP_BYTE    = RSP_BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_cmd_ctrl_if.slave  bus
);

  state_t r_state, w_state_nxt;

  // frame capture
  logic [7:0]        r_xor;        // running CMD^ADDR^DATA
  logic              r_is_rd;
  logic              r_cmd_ok;
  logic [ADDR_W-1:0] r_addr_sh;    // in-flight frame, committed on accept
  logic [7:0]        r_data_sh;

  // registered outputs / reply data
  logic [ADDR_W-1:0] r_reg_addr;
  logic [7:0]        r_reg_wr_data;
  logic [7:0]        r_rd_data;
  logic              r_frame_err;
  logic [7:0]        r_err_cnt;

  logic       w_in_frame, w_tc, w_chk_ok, w_accept, w_timeout, w_err;
  logic       w_reg_wr_en, w_reg_rd_en, w_tx_valid;
  logic [7:0] w_tx_data;

  assign w_in_frame = (r_state == S_CMD) || (r_state == S_ADDR) ||
                      (r_state == S_DATA) || (r_state == S_CHK);

  uart_cmd_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (bus.rx_valid || !w_in_frame),
    .i_en  (w_in_frame),
    .o_tc  (w_tc)
  );

  // An invalid opcode is only reported here, together with the checksum.
  assign w_chk_ok  = (bus.rx_data == r_xor) && r_cmd_ok;
  assign w_accept  = (r_state == S_CHK) && bus.rx_valid && w_chk_ok;
  // A byte arriving on the terminal-count cycle keeps the frame alive.
  assign w_timeout = w_in_frame && !bus.rx_valid && w_tc;
  assign w_err     = ((r_state == S_CHK) && bus.rx_valid && !w_chk_ok) || w_timeout;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_HDR:    if (bus.rx_valid && bus.rx_data == HDR_BYTE) w_state_nxt = S_CMD;
      S_CMD:    if (bus.rx_valid) w_state_nxt = S_ADDR;
                else if (w_tc)    w_state_nxt = S_HDR;
      S_ADDR:   if (bus.rx_valid) w_state_nxt = S_DATA;
                else if (w_tc)    w_state_nxt = S_HDR;
      S_DATA:   if (bus.rx_valid) w_state_nxt = S_CHK;
                else if (w_tc)    w_state_nxt = S_HDR;
      S_CHK:    if (bus.rx_valid) w_state_nxt = w_chk_ok ? S_EXEC : S_HDR;
                else if (w_tc)    w_state_nxt = S_HDR;
      S_EXEC:   w_state_nxt = r_is_rd ? S_RDWAIT : S_HDR;
      S_RDWAIT: w_state_nxt = S_TXHDR;
      S_TXHDR:  if (bus.tx_ready) w_state_nxt = S_TXDAT;
      S_TXDAT:  if (bus.tx_ready) w_state_nxt = S_HDR;
      default:  w_state_nxt = S_HDR;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Decoded from state only, so reset drops strobes and tx_valid at once.
  always_comb begin
    w_reg_wr_en = 1'b0;
    w_reg_rd_en = 1'b0;
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    case (r_state)
      S_EXEC: begin
        w_reg_wr_en = !r_is_rd;
        w_reg_rd_en = r_is_rd;
      end
      S_TXHDR: begin
        w_tx_valid = 1'b1;
        w_tx_data  = RSP_BYTE;
      end
      S_TXDAT: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_rd_data;
      end
      default: ;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xor         <= 8'h00;
      r_is_rd       <= 1'b0;
      r_cmd_ok      <= 1'b0;
      r_addr_sh     <= '0;
      r_data_sh     <= 8'h00;
      r_reg_addr    <= '0;
      r_reg_wr_data <= 8'h00;
      r_rd_data     <= 8'h00;
      r_frame_err   <= 1'b0;
      r_err_cnt     <= 8'h00;
    end else begin
      r_frame_err <= w_err;
      if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;

      if (bus.rx_valid) begin
        case (r_state)
          S_CMD: begin
            r_xor    <= bus.rx_data;
            r_is_rd  <= (bus.rx_data == CMD_RD);
            r_cmd_ok <= (bus.rx_data == CMD_WR) || (bus.rx_data == CMD_RD);
          end
          S_ADDR: begin
            r_xor     <= r_xor ^ bus.rx_data;
            r_addr_sh <= bus.rx_data[ADDR_W-1:0];
          end
          S_DATA: begin
            r_xor     <= r_xor ^ bus.rx_data;
            r_data_sh <= bus.rx_data;
          end
          default: ;
        endcase
      end

      // Register-bank outputs only move on an accepted frame; read DATA is
      // a don't-care and does not disturb reg_wr_data.
      if (w_accept) begin
        r_reg_addr <= r_addr_sh;
        if (!r_is_rd) r_reg_wr_data <= r_data_sh;
      end

      if (r_state == S_RDWAIT) r_rd_data <= bus.reg_rd_data;
    end
  end

  assign bus.reg_wr_en   = w_reg_wr_en;
  assign bus.reg_rd_en   = w_reg_rd_en;
  assign bus.reg_addr    = r_reg_addr;
  assign bus.reg_wr_data = r_reg_wr_data;
  assign bus.tx_valid    = w_tx_valid;
  assign bus.tx_data     = w_tx_data;
  assign bus.busy        = (r_state != S_HDR);
  assign bus.frame_err   = r_frame_err;
  assign bus.err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int TMO = 40;

  logic clk, rst_n;
  uart_cmd_ctrl_if #(.ADDR_W(8)) bus ();

  uart_cmd_ctrl #(.ADDR_W(8), .TIMEOUT_CYC(TMO), .HDR_BYTE(8'hAA), .RSP_BYTE(8'h55)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_wr = 0, n_rd = 0, n_err = 0;
  int exp_n_err = 0;
  logic [7:0] exp_ecnt = 8'h00;

  always @(negedge clk) begin
    if (bus.reg_wr_en) n_wr++;
    if (bus.reg_rd_en) n_rd++;
    if (bus.frame_err) n_err++;
  end

  typedef struct {
    logic [7:0] cmd, addr, data, chk, rd;
    logic       exp_wr, exp_rd, exp_err;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, a, d, k);
    logic [7:0] fb [FRAME_LEN];
    fb[0] = 8'hAA; fb[1] = c; fb[2] = a; fb[3] = d; fb[4] = k;
    for (int j = 0; j < FRAME_LEN; j++) send_byte(fb[j]);
  endtask

  task automatic note_err();
    exp_n_err++;
    if (exp_ecnt != 8'hFF) exp_ecnt = exp_ecnt + 8'h01;
  endtask

  // Collects up to two reply bytes; call right after the CHK strobe.
  task automatic get_tx(output logic [7:0] d0, output logic [7:0] d1, output int got);
    got = 0; d0 = 8'h00; d1 = 8'h00;
    for (int i = 0; i < 30 && got < 2; i++) begin
      if (bus.tx_valid && bus.tx_ready) begin
        if (got == 0) d0 = bus.tx_data; else d1 = bus.tx_data;
        got++;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t0, t1;
    int got, wr0, err0;
    logic ok;

    tv[0] = '{8'h01, 8'h10, 8'h5A, 8'h4B, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[1] = '{8'h02, 8'h20, 8'h00, 8'h22, 8'hC3, 1'b0, 1'b1, 1'b0};
    tv[2] = '{8'h01, 8'h10, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    tv[3] = '{8'h01, 8'h05, 8'h07, 8'h03, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[4] = '{8'h03, 8'h10, 8'h00, 8'h13, 8'h00, 1'b0, 1'b0, 1'b1};
    tv[5] = '{8'h01, 8'hFF, 8'h00, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0};
    tv[6] = '{8'h02, 8'h7E, 8'h99, 8'hE5, 8'h3C, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus.reg_rd_data = 8'h00; bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_outs", {bus.reg_wr_en, bus.reg_rd_en, bus.tx_valid, bus.frame_err}, 0);
    chk("rst_regs", {bus.reg_addr, bus.reg_wr_data, bus.tx_data, bus.err_cnt}, 0);
    rst_n = 1'b1;

    // ---------------- table-driven frames ----------------
    for (int i = 0; i < 7; i++) begin
      bus.reg_rd_data = tv[i].rd;
      bus.tx_ready    = 1'b1;
      send_frame(tv[i].cmd, tv[i].addr, tv[i].data, tv[i].chk);
      chk($sformatf("v%0d_wr_en", i), bus.reg_wr_en, tv[i].exp_wr);
      chk($sformatf("v%0d_rd_en", i), bus.reg_rd_en, tv[i].exp_rd);
      chk($sformatf("v%0d_ferr", i), bus.frame_err, tv[i].exp_err);
      if (tv[i].exp_wr) begin
        chk($sformatf("v%0d_addr", i), bus.reg_addr, tv[i].addr);
        chk($sformatf("v%0d_wdata", i), bus.reg_wr_data, tv[i].data);
      end
      if (tv[i].exp_rd) begin
        chk($sformatf("v%0d_raddr", i), bus.reg_addr, tv[i].addr);
        get_tx(t0, t1, got);
        chk($sformatf("v%0d_tx_cnt", i), got, 2);
        chk($sformatf("v%0d_tx0", i), t0, 8'h55);
        chk($sformatf("v%0d_tx1", i), t1, tv[i].rd);
        chk($sformatf("v%0d_tx_drop", i), bus.tx_valid, 0);
      end
      if (tv[i].exp_err) begin
        note_err();
        chk($sformatf("v%0d_errcnt", i), bus.err_cnt, exp_ecnt);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", i), {bus.busy, bus.frame_err}, 0);
    end
    bus.tx_ready = 1'b0;
    chk("tbl_err_pulses", n_err, exp_n_err);

    // ---------------- read reply with tx_ready stalled ----------------
    bus.reg_rd_data = 8'hC3;
    send_frame(8'h02, 8'h20, 8'h00, 8'h22);
    chk("stall_rd_en", bus.reg_rd_en, 1);
    @(posedge clk); #1;               // S_RDWAIT
    @(posedge clk); #1;               // S_TXHDR
    bus.reg_rd_data = 8'h00;
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'h55)) ok = 1'b0;
      bus.rx_valid = (i == 10 || i == 20);   // stray bytes while busy
      bus.rx_data  = 8'hAA;
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
    chk("stall_hdr_stable", ok, 1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(bus.tx_valid === 1'b1 && bus.tx_data === 8'hC3)) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("stall_dat_stable", ok, 1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.tx_ready = 1'b0;
    chk("stall_tx_drop", {bus.tx_valid, bus.busy}, 0);
    chk("stall_no_err", n_err, exp_n_err);

    // ---------------- inter-byte timeout ----------------
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("tmo_before", {bus.busy, bus.frame_err}, 2'b10);
    @(posedge clk); #1;
    note_err();
    chk("tmo_fire", {bus.busy, bus.frame_err}, 2'b01);
    chk("tmo_errcnt", bus.err_cnt, exp_ecnt);
    wr0 = n_wr;
    send_frame(8'h01, 8'h10, 8'h5A, 8'h4B);
    chk("tmo_recover_wr", bus.reg_wr_en, 1);

    // byte on the terminal-count cycle keeps the frame alive
    @(posedge clk); #1;
    send_byte(8'hAA);
    send_byte(8'h01);
    repeat (TMO - 2) @(posedge clk);
    #1;
    send_byte(8'h33);
    chk("tc_race_busy", {bus.busy, bus.frame_err}, 2'b10);
    send_byte(8'h44);
    send_byte(8'h76);                 // 01^33^44 = 76
    chk("tc_race_wr", {bus.reg_wr_en, bus.reg_addr, bus.reg_wr_data}, {1'b1, 8'h33, 8'h44});
    @(posedge clk); #1;
    chk("tc_race_errs", n_err, exp_n_err);

    // ---------------- garbage before header ----------------
    send_byte(8'h12);
    send_byte(8'h34);
    chk("garb_idle", {bus.busy, bus.frame_err}, 0);
    send_frame(8'h01, 8'h05, 8'h07, 8'h03);
    chk("garb_wr", {bus.reg_wr_en, bus.reg_addr, bus.reg_wr_data}, {1'b1, 8'h05, 8'h07});
    @(posedge clk); #1;
    chk("garb_no_err", n_err, exp_n_err);

    // ---------------- err_cnt saturation ----------------
    for (int i = 0; i < 300; i++) begin
      send_frame(8'h01, 8'h10, 8'h5A, 8'h00);
      note_err();
    end
    @(posedge clk); #1;
    chk("sat_errcnt", bus.err_cnt, 8'hFF);
    chk("sat_pulses", n_err, exp_n_err);

    // ---------------- reset mid-frame ----------------
    wr0 = n_wr; err0 = n_err;
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h10);
    chk("mid_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_outs", {bus.reg_wr_en, bus.reg_rd_en, bus.tx_valid, bus.frame_err}, 0);
    chk("mid_rst_regs", {bus.reg_addr, bus.reg_wr_data, bus.tx_data, bus.err_cnt}, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send_byte(8'h5A);
    send_byte(8'h4B);
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_write", n_wr, wr0);
    chk("mid_no_err", n_err, err0);
    chk("mid_idle", {bus.busy, bus.err_cnt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
